mhpm_overflow_event_gen: RTL

MHPM_OVERFLOW_EVENT_GEN -- requirements
Module: mhpm_overflow_event_gen

---
 rtl/mhpm_ovf_pkg.sv | 34 +++
 rtl/mhpm_counter_slice.sv | 56 +++++
 rtl/mhpm_overflow_event_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/mhpm_ovf_pkg.sv
// Shared constants and types for the HPM overflow event generator.
// Used by mhpm_counter_slice and mhpm_overflow_event_gen.
package mhpm_ovf_pkg;

  // Counter i is architectural mhpmcounter(HPM_BASE_IDX + i).
  localparam int HPM_BASE_IDX = 3;
  localparam int DEF_NUM_CNT  = 8;
  localparam int DEF_CNT_W    = 64;
  localparam int OVF_W        = 64;

  typedef enum logic {
    CK_COUNTER = 1'b0,
    CK_EVENT   = 1'b1
  } csr_kind_e;

  // Per-slice write controls decoded from the shared CSR write port.
  typedef struct packed {
    logic cnt_wr;
    logic evt_wr;
  } slice_wr_t;

  function automatic slice_wr_t decode_wr(input logic       wen,
                                          input csr_kind_e  kind,
                                          input logic [4:0] idx,
                                          input int         slot);
    slice_wr_t wr;
    logic      hit;
    hit       = wen && (idx == 5'(slot));
    wr.cnt_wr = hit && (kind == CK_COUNTER);
    wr.evt_wr = hit && (kind == CK_EVENT);
    return wr;
  endfunction

endpackage

// File: rtl/mhpm_counter_slice.sv
// One hardware performance counter with its sticky overflow flag.
// A CSR counter write beats an increment; a hardware overflow beats an event write.
module mhpm_counter_slice
  import mhpm_ovf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_en,
  input  logic             cnt_wr,
  input  logic             evt_wr,
  input  logic [CNT_W-1:0] wdata,
  input  logic             of_wdata,
  output logic [CNT_W-1:0] cnt,
  output logic             of_flag
);

  logic [CNT_W-1:0] cnt_d;
  logic             of_d;
  logic             hw_ovf;

  // The wrap only counts as an overflow when the increment really lands.
  assign hw_ovf = inc_en && !cnt_wr && (&cnt);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt;
    if (cnt_wr) begin
      cnt_d = wdata;
    end else if (inc_en) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  always_comb begin
    of_d = of_flag;
    if (hw_ovf) begin
      of_d = 1'b1;
    end else if (evt_wr) begin
      of_d = of_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      of_flag <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      of_flag <= of_d;
    end
  end

endmodule

// File: rtl/mhpm_overflow_event_gen.sv
// HPM counter bank with overflow vector, difftest change events and optional LCOFI.
// Define MHPM_LCOFI_IRQ_EN to build the local counter-overflow interrupt.
module mhpm_overflow_event_gen
  import mhpm_ovf_pkg::*;
#(
  parameter int NUM_CNT = DEF_NUM_CNT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               io_coreid,
  input  logic [NUM_CNT-1:0]       inc,
  input  logic [NUM_CNT-1:0]       inhibit,
  input  logic                     csr_wen,
  input  logic                     csr_kind,
  input  logic [4:0]               csr_idx,
  input  logic [63:0]              csr_wdata,
  input  logic                     lcofi_clr,
  output logic [NUM_CNT*CNT_W-1:0] cnt_out,
  output logic [OVF_W-1:0]         ovf_vec,
  output logic                     dt_enable,
  output logic                     dt_valid,
  output logic [OVF_W-1:0]         dt_mhpmeventOverflow,
  output logic [7:0]               dt_coreid,
  output logic                     lcofi_pending
);

  csr_kind_e          kind;
  logic [NUM_CNT-1:0] of_bits;
  logic [OVF_W-1:0]   ovf_shadow;
  logic               ovf_changed;

  assign kind = csr_kind_e'(csr_kind);

  // Indices at or above NUM_CNT match no slot, so such writes fall away.
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_slice
    slice_wr_t wr;
    assign wr = decode_wr(csr_wen, kind, csr_idx, i);

    mhpm_counter_slice #(
      .CNT_W (CNT_W)
    ) u_slice (
      .clock    (clock),
      .reset    (reset),
      .inc_en   (inc[i] && !inhibit[i]),
      .cnt_wr   (wr.cnt_wr),
      .evt_wr   (wr.evt_wr),
      .wdata    (csr_wdata[CNT_W-1:0]),
      .of_wdata (csr_wdata[63]),
      .cnt      (cnt_out[i*CNT_W +: CNT_W]),
      .of_flag  (of_bits[i])
    );
  end

  // The OF flags are flops, so the vector is already registered state.
  always_comb begin
    ovf_vec                            = '0;
    ovf_vec[HPM_BASE_IDX +: NUM_CNT]   = of_bits;
  end

  assign ovf_changed = (ovf_vec != ovf_shadow);

  // NOTE: reset clears every flop including the shadow, so leaving reset never looks like a change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_shadow           <= '0;
      dt_valid             <= 1'b0;
      dt_enable            <= 1'b0;
      dt_mhpmeventOverflow <= '0;
      dt_coreid            <= '0;
    end else begin
      ovf_shadow <= ovf_vec;
      dt_valid   <= ovf_changed;
      dt_enable  <= ovf_changed;
      dt_coreid  <= io_coreid;
      if (ovf_changed) begin
        dt_mhpmeventOverflow <= ovf_vec;
      end
    end
  end

`ifdef MHPM_LCOFI_IRQ_EN
  logic of_rise;

  assign of_rise = |(ovf_vec & ~ovf_shadow);

  // A rise in the same cycle as a clear keeps the request raised.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lcofi_pending <= 1'b0;
    end else begin
      lcofi_pending <= of_rise || (lcofi_pending && !lcofi_clr);
    end
  end
`else
  logic unused_lcofi_clr;

  assign unused_lcofi_clr = lcofi_clr;
  assign lcofi_pending    = 1'b0;
`endif

endmodule
